bus_master: RTL and testbench

BUS_MASTER -- requirements
Module: bus_master

---
 rtl/bus_master_if.sv | 34 +++
 rtl/bus_master.sv | 138 +++++++++++++
 tb/tb_bus_master.sv | 231 +++++++++++++++++++++++
 3 files changed

// File: rtl/bus_master_if.sv
// Client request/response and two-phase slave bus bundle for bus_master.
interface bus_master_if #(
   parameter int unsigned ADDR_W = 16,
   parameter int unsigned DATA_W = 16
);
   localparam int unsigned CNT_W = 16;

   logic              req_valid;
   logic              req_ready;
   logic              req_write;
   logic [ADDR_W-1:0] req_addr;
   logic [DATA_W-1:0] req_wdata;
   logic              rsp_valid;
   logic [DATA_W-1:0] rsp_rdata;
   logic [CNT_W-1:0]  txn_count;
   logic              sel;
   logic              enable;
   logic              wr_dir;
   logic [ADDR_W-1:0] addr;
   logic [DATA_W-1:0] wdata;
   logic [DATA_W-1:0] rdata;

   modport master (
      input  req_valid, req_write, req_addr, req_wdata, rdata,
      output req_ready, rsp_valid, rsp_rdata, txn_count,
             sel, enable, wr_dir, addr, wdata
   );

   modport slave (
      output req_valid, req_write, req_addr, req_wdata, rdata,
      input  req_ready, rsp_valid, rsp_rdata, txn_count,
             sel, enable, wr_dir, addr, wdata
   );
endinterface

// File: rtl/bus_master.sv
// Single-outstanding bus master: client handshake -> SETUP/ACCESS bus cycle -> one-cycle response.
module bus_master #(
   parameter int unsigned ADDR_W = 16,
   parameter int unsigned DATA_W = 16
) (
   input logic          clk,
   input logic          rst,
   bus_master_if.master bus
);
   localparam int unsigned CNT_W = 16;

   typedef enum logic [2:0] {
      IDLE    = 3'd0,
      SETUP   = 3'd1,
      ACCESS  = 3'd2,
      CAPTURE = 3'd3,
      RESP    = 3'd4
   } state_t;

   state_t            state;
   state_t            state_next;

   logic              sel_d;
   logic              enable_d;
   logic              ready_d;
   logic              rsp_valid_d;

   logic              sel_q;
   logic              enable_q;
   logic              ready_q;
   logic              rsp_valid_q;

   logic              write_q;
   logic [ADDR_W-1:0] addr_q;
   logic [DATA_W-1:0] wdata_q;
   logic [DATA_W-1:0] rdata_q;
   logic [CNT_W-1:0]  txn_q;

   logic              handshake_c;

   // ready_q mirrors (state == IDLE), so the handshake never looks at anything but flops and req_valid
   assign handshake_c = bus.req_valid && ready_q;

   // State register
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state <= IDLE;
      end else begin
         state <= state_next;
      end
   end

   // Next-state logic
   always_comb begin
      state_next = state;
      unique case (state)
         IDLE:    if (handshake_c) state_next = SETUP;
         SETUP:   state_next = ACCESS;
         ACCESS:  state_next = write_q ? RESP : CAPTURE;
         CAPTURE: state_next = RESP;
         RESP:    state_next = IDLE;
         default: state_next = IDLE;
      endcase
   end

   // Output decode of the upcoming state; registered below so outputs track the state register exactly
   always_comb begin
      sel_d       = 1'b0;
      enable_d    = 1'b0;
      ready_d     = 1'b0;
      rsp_valid_d = 1'b0;
      unique case (state_next)
         IDLE:    ready_d = 1'b1;
         SETUP:   sel_d = 1'b1;
         ACCESS: begin
            sel_d    = 1'b1;
            enable_d = 1'b1;
         end
         RESP:    rsp_valid_d = 1'b1;
         default: ;
      endcase
   end

   // Control output flops
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         sel_q       <= 1'b0;
         enable_q    <= 1'b0;
         ready_q     <= 1'b1;
         rsp_valid_q <= 1'b0;
      end else begin
         sel_q       <= sel_d;
         enable_q    <= enable_d;
         ready_q     <= ready_d;
         rsp_valid_q <= rsp_valid_d;
      end
   end

   // Request latch, read-data capture and completion counter
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         write_q <= 1'b0;
         addr_q  <= '0;
         wdata_q <= '0;
         rdata_q <= '0;
         txn_q   <= '0;
      end else begin
         if (handshake_c) begin
            write_q <= bus.req_write;
            addr_q  <= bus.req_addr;
            wdata_q <= bus.req_wdata;
         end
         if (state == CAPTURE) begin
            rdata_q <= bus.rdata;
         end
         if (state == RESP) begin
            txn_q <= txn_q + CNT_W'(1);
         end
      end
   end

   assign bus.req_ready = ready_q;
   assign bus.rsp_valid = rsp_valid_q;
   assign bus.rsp_rdata = rdata_q;
   assign bus.txn_count = txn_q;
   assign bus.sel       = sel_q;
   assign bus.enable    = enable_q;
   assign bus.wr_dir    = write_q;
   assign bus.addr      = addr_q;
   assign bus.wdata     = wdata_q;

   // Bus protocol invariants
   a_enable_needs_sel : assert property (@(posedge clk) disable iff (rst) bus.enable |-> bus.sel);
   a_rsp_single_pulse : assert property (@(posedge clk) disable iff (rst) bus.rsp_valid |=> !bus.rsp_valid);
   a_sel_max_two      : assert property (@(posedge clk) disable iff (rst)
                                         (bus.sel && $past(bus.sel)) |=> !bus.sel);

endmodule

// File: tb/tb_bus_master.sv
// Directed self-checking bench for bus_master with a small memory slave model.
module tb_bus_master;
   localparam int unsigned ADDR_W = 16;
   localparam int unsigned DATA_W = 16;

   logic clk = 1'b0;
   logic rst;

   always #5 clk = ~clk;

   bus_master_if #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) bif ();

   bus_master #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) dut (
      .clk (clk),
      .rst (rst),
      .bus (bif)
   );

   logic [15:0] mem [0:255];
   int          n_checks = 0;
   int          n_errors = 0;
   int          cyc      = 0;
   int          sel_run  = 0;
   int          hs_cyc   = 0;

   // Slave: registers read data at the ACCESS edge, writes memory at the same edge
   always @(posedge clk) begin
      if (bif.sel && bif.enable) begin
         if (bif.wr_dir) mem[bif.addr[7:0]] <= bif.wdata;
         else            bif.rdata <= mem[bif.addr[7:0]];
      end
   end

   always @(posedge clk) cyc <= cyc + 1;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_errors++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
      end
   endtask

   // Protocol monitor: enable implies sel, sel never high more than 2 cycles running
   always @(negedge clk) begin
      if (rst === 1'b0) begin
         check("en_without_sel", 32'(bif.enable & ~bif.sel), 32'd0);
         if (bif.sel) sel_run++;
         else         sel_run = 0;
         check("sel_run_le2", 32'(sel_run <= 2), 32'd1);
      end else begin
         sel_run = 0;
      end
   end

   task automatic run_txn(input logic wr, input logic [15:0] a, input logic [15:0] d,
                          input bit keep_valid, output int lat, output logic [15:0] rd);
      int budget;
      int scnt;
      int eidx;
      @(negedge clk);
      bif.req_valid = 1'b1;
      bif.req_write = wr;
      bif.req_addr  = a;
      bif.req_wdata = d;
      budget = 0;
      while (bif.req_ready !== 1'b1 && budget < 20) begin
         @(negedge clk);
         budget++;
      end
      check("hs_wait", 32'(budget < 20), 32'd1);
      @(posedge clk);
      #1;
      hs_cyc = cyc;
      if (!keep_valid) bif.req_valid = 1'b0;
      bif.req_addr  = ~a;
      bif.req_wdata = ~d;
      bif.req_write = ~wr;
      lat  = 1;
      scnt = 0;
      eidx = 0;
      while (bif.rsp_valid !== 1'b1 && lat < 10) begin
         if (bif.sel) begin
            scnt++;
            check("addr_latched", 32'(bif.addr), 32'(a));
            check("wdata_latched", 32'(bif.wdata), 32'(d));
            check("wr_dir", 32'(bif.wr_dir), 32'(wr));
         end
         if (bif.enable) eidx = lat;
         check("ready_low_busy", 32'(bif.req_ready), 32'd0);
         @(posedge clk);
         #1;
         lat++;
      end
      check("sel_cycles", 32'(scnt), 32'd2);
      check("enable_cycle", 32'(eidx), 32'd2);
      check("rsp_latency", 32'(lat), wr ? 32'd3 : 32'd4);
      check("rsp_sel_low", 32'(bif.sel), 32'd0);
      rd = bif.rsp_rdata;
      @(posedge clk);
      #1;
      check("rsp_one_cycle", 32'(bif.rsp_valid), 32'd0);
      check("ready_in_idle", 32'(bif.req_ready), 32'd1);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: got timeout expected finish");
      $fatal(1, "watchdog");
   end

   initial begin
      int          lat;
      int          prev_hs;
      int          budget;
      logic [15:0] rd;
      logic        cw [0:3];
      logic [15:0] ca [0:3];
      logic [15:0] cd [0:3];
      logic [15:0] ce [0:3];

      for (int i = 0; i < 256; i++) mem[i] = 16'h0000;
      rst           = 1'b1;
      bif.req_valid = 1'b0;
      bif.req_write = 1'b0;
      bif.req_addr  = '0;
      bif.req_wdata = '0;

      // Reset values
      repeat (2) @(negedge clk);
      check("rst_sel", 32'(bif.sel), 32'd0);
      check("rst_enable", 32'(bif.enable), 32'd0);
      check("rst_wr_dir", 32'(bif.wr_dir), 32'd0);
      check("rst_addr", 32'(bif.addr), 32'd0);
      check("rst_wdata", 32'(bif.wdata), 32'd0);
      check("rst_rsp_valid", 32'(bif.rsp_valid), 32'd0);
      check("rst_rsp_rdata", 32'(bif.rsp_rdata), 32'd0);
      check("rst_txn", 32'(bif.txn_count), 32'd0);
      check("rst_ready", 32'(bif.req_ready), 32'd1);
      rst = 1'b0;

      // Write then read back
      run_txn(1'b1, 16'h0010, 16'hBEEF, 1'b0, lat, rd);
      check("w1_txn", 32'(bif.txn_count), 32'd1);
      check("w1_mem", 32'(mem[8'h10]), 32'h0000BEEF);
      run_txn(1'b0, 16'h0010, 16'h0000, 1'b0, lat, rd);
      check("r1_rdata", 32'(rd), 32'h0000BEEF);
      check("r1_txn", 32'(bif.txn_count), 32'd2);

      // rsp_rdata holds across a write
      run_txn(1'b1, 16'h0020, 16'h1234, 1'b0, lat, rd);
      check("w2_rdata_hold", 32'(rd), 32'h0000BEEF);
      check("w2_txn", 32'(bif.txn_count), 32'd3);

      // Back-to-back with req_valid held high, alternating write/read
      cw[0] = 1'b1; ca[0] = 16'h0030; cd[0] = 16'hA5A5; ce[0] = 16'h0000;
      cw[1] = 1'b0; ca[1] = 16'h0030; cd[1] = 16'h0000; ce[1] = 16'hA5A5;
      cw[2] = 1'b1; ca[2] = 16'h0031; cd[2] = 16'h5A5A; ce[2] = 16'h0000;
      cw[3] = 1'b0; ca[3] = 16'h0031; cd[3] = 16'h0000; ce[3] = 16'h5A5A;
      prev_hs = 0;
      for (int i = 0; i < 4; i++) begin
         run_txn(cw[i], ca[i], cd[i], 1'b1, lat, rd);
         if (i > 0) check("issue_spacing", 32'(hs_cyc - prev_hs), cw[i-1] ? 32'd4 : 32'd5);
         if (!cw[i]) check("cont_rdata", 32'(rd), 32'(ce[i]));
         prev_hs = hs_cyc;
      end
      bif.req_valid = 1'b0;
      check("cont_txn", 32'(bif.txn_count), 32'd7);

      // Reset during ACCESS of a read aborts it
      @(negedge clk);
      bif.req_valid = 1'b1;
      bif.req_write = 1'b0;
      bif.req_addr  = 16'h0010;
      @(posedge clk);
      #1;
      bif.req_valid = 1'b0;
      @(posedge clk);
      #1;
      check("abort_in_access", 32'(bif.enable), 32'd1);
      #1;
      rst = 1'b1;
      #1;
      check("abort_sel", 32'(bif.sel), 32'd0);
      check("abort_enable", 32'(bif.enable), 32'd0);
      check("abort_addr", 32'(bif.addr), 32'd0);
      check("abort_rsp_valid", 32'(bif.rsp_valid), 32'd0);
      check("abort_rsp_rdata", 32'(bif.rsp_rdata), 32'd0);
      check("abort_txn", 32'(bif.txn_count), 32'd0);
      repeat (2) @(negedge clk);
      check("abort_no_rsp", 32'(bif.rsp_valid), 32'd0);

      // First handshake at the first edge after reset release
      bif.req_valid = 1'b1;
      bif.req_write = 1'b1;
      bif.req_addr  = 16'h0040;
      bif.req_wdata = 16'hCAFE;
      rst = 1'b0;
      @(posedge clk);
      #1;
      bif.req_valid = 1'b0;
      check("post_rst_setup", 32'(bif.sel), 32'd1);
      check("post_rst_busy", 32'(bif.req_ready), 32'd0);
      budget = 1;
      while (bif.rsp_valid !== 1'b1 && budget < 10) begin
         @(posedge clk);
         #1;
         budget++;
      end
      check("post_rst_latency", 32'(budget), 32'd3);
      @(posedge clk);
      #1;
      check("post_rst_txn", 32'(bif.txn_count), 32'd1);
      check("post_rst_mem", 32'(mem[8'h40]), 32'h0000CAFE);

      // Counter wrap
      @(negedge clk);
      force dut.txn_q = 16'hFFFF;
      #1;
      release dut.txn_q;
      check("wrap_preload", 32'(bif.txn_count), 32'h0000FFFF);
      run_txn(1'b1, 16'h0050, 16'h0F0F, 1'b0, lat, rd);
      check("wrap_txn", 32'(bif.txn_count), 32'h00000000);
      check("wrap_mem", 32'(mem[8'h50]), 32'h00000F0F);

      repeat (2) @(negedge clk);
      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule
